// File: rtl/ysyx_23060077_riscv_id_ex_stage_pkg.sv
// Shared widths, operand-select encodings and ALU opcodes for the ID/EX boundary.
// The ALU opcode values match the ones the EX ALU decodes.
package ysyx_23060077_riscv_id_ex_stage_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int ALU_OPT_WIDTH  = 4;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic A_SEL_RS1 = 1'b0;
  localparam logic A_SEL_PC  = 1'b1;
  localparam logic B_SEL_RS2 = 1'b0;
  localparam logic B_SEL_IMM = 1'b1;

  localparam logic [ALU_OPT_WIDTH-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_SLL  = 4'd2;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_SLT  = 4'd3;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_SLTU = 4'd4;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_XOR  = 4'd5;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_OR   = 4'd8;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_AND  = 4'd9;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_LUI  = 4'd10;

endpackage

// File: rtl/ysyx_23060077_riscv_ex_fwd.sv
// Combinational operand bypass for one source register: MEM result, then WB
// write, then the value held in the ID/EX register. x0 always reads as zero.
module ysyx_23060077_riscv_ex_fwd #(
  parameter int DATA_WIDTH     = ysyx_23060077_riscv_id_ex_stage_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = ysyx_23060077_riscv_id_ex_stage_pkg::REG_ADDR_WIDTH
) (
  input  logic [REG_ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0]     i_data,
  input  logic                      i_mem_wen,
  input  logic [REG_ADDR_WIDTH-1:0] i_mem_addr,
  input  logic [DATA_WIDTH-1:0]     i_mem_data,
  input  logic                      i_wb_wen,
  input  logic [REG_ADDR_WIDTH-1:0] i_wb_addr,
  input  logic [DATA_WIDTH-1:0]     i_wb_data,
  output logic [DATA_WIDTH-1:0]     o_data
);

  // MEM is checked first because it holds the younger producer.
  always_comb begin
    o_data = i_data;
    if (i_addr == '0) begin
      o_data = '0;
    end else if (i_mem_wen && (i_mem_addr == i_addr)) begin
      o_data = i_mem_data;
    end else if (i_wb_wen && (i_wb_addr == i_addr)) begin
      o_data = i_wb_data;
    end
  end

endmodule

// File: rtl/ysyx_23060077_riscv_id_ex_stage.sv
// ID->EX pipeline register with valid/ready handshake, operand selection and
// RAW hazard resolution (MEM/WB bypass plus WB snooping while stalled).
module ysyx_23060077_riscv_id_ex_stage #(
  parameter int DATA_WIDTH     = ysyx_23060077_riscv_id_ex_stage_pkg::DATA_WIDTH,
  parameter int ALU_OPT_WIDTH  = ysyx_23060077_riscv_id_ex_stage_pkg::ALU_OPT_WIDTH,
  parameter int REG_ADDR_WIDTH = ysyx_23060077_riscv_id_ex_stage_pkg::REG_ADDR_WIDTH
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_flush,
  input  logic                      i_id_valid,
  output logic                      o_id_ready,
  input  logic [DATA_WIDTH-1:0]     i_id_pc,
  input  logic [ALU_OPT_WIDTH-1:0]  i_id_alu_opt,
  input  logic                      i_id_a_sel,
  input  logic                      i_id_b_sel,
  input  logic [DATA_WIDTH-1:0]     i_id_imm,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rs2_addr,
  input  logic [DATA_WIDTH-1:0]     i_id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     i_id_rs2_data,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rd_addr,
  input  logic                      i_id_rd_wen,
  input  logic                      i_mem_fwd_wen,
  input  logic [REG_ADDR_WIDTH-1:0] i_mem_fwd_addr,
  input  logic [DATA_WIDTH-1:0]     i_mem_fwd_data,
  input  logic                      i_wb_wen,
  input  logic [REG_ADDR_WIDTH-1:0] i_wb_addr,
  input  logic [DATA_WIDTH-1:0]     i_wb_data,
  output logic                      o_ex_valid,
  input  logic                      i_ex_ready,
  output logic [DATA_WIDTH-1:0]     o_ex_pc,
  output logic [ALU_OPT_WIDTH-1:0]  o_ex_alu_opt,
  output logic [DATA_WIDTH-1:0]     o_ex_alu_a_data,
  output logic [DATA_WIDTH-1:0]     o_ex_alu_b_data,
  output logic [DATA_WIDTH-1:0]     o_ex_store_data,
  output logic [REG_ADDR_WIDTH-1:0] o_ex_rd_addr,
  output logic                      o_ex_rd_wen
);

  import ysyx_23060077_riscv_id_ex_stage_pkg::*;

  logic                      r_valid;
  logic [DATA_WIDTH-1:0]     r_pc;
  logic [ALU_OPT_WIDTH-1:0]  r_alu_opt;
  logic                      r_a_sel;
  logic                      r_b_sel;
  logic [DATA_WIDTH-1:0]     r_imm;
  logic [REG_ADDR_WIDTH-1:0] r_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] r_rs2_addr;
  logic [DATA_WIDTH-1:0]     r_rs1_data;
  logic [DATA_WIDTH-1:0]     r_rs2_data;
  logic [REG_ADDR_WIDTH-1:0] r_rd_addr;
  logic                      r_rd_wen;

  logic                      w_id_ready;
  logic                      w_capture;
  logic [DATA_WIDTH-1:0]     w_rs1_cap;
  logic [DATA_WIDTH-1:0]     w_rs2_cap;
  logic                      w_rs1_snoop;
  logic                      w_rs2_snoop;
  logic [DATA_WIDTH-1:0]     w_rs1_fwd;
  logic [DATA_WIDTH-1:0]     w_rs2_fwd;

  assign w_id_ready = !r_valid || i_ex_ready;
  assign w_capture  = i_id_valid && w_id_ready && !i_flush;

  // A WB write landing in the same cycle as the regfile read is taken here.
  assign w_rs1_cap = (i_wb_wen && (i_wb_addr == i_id_rs1_addr) && (i_id_rs1_addr != '0))
                     ? i_wb_data : i_id_rs1_data;
  assign w_rs2_cap = (i_wb_wen && (i_wb_addr == i_id_rs2_addr) && (i_id_rs2_addr != '0))
                     ? i_wb_data : i_id_rs2_data;
  assign w_rs1_snoop = i_wb_wen && (i_wb_addr == r_rs1_addr) && (r_rs1_addr != '0);
  assign w_rs2_snoop = i_wb_wen && (i_wb_addr == r_rs2_addr) && (r_rs2_addr != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_id_ready) begin
      r_valid <= i_id_valid;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc       <= '0;
      r_alu_opt  <= '0;
      r_a_sel    <= A_SEL_RS1;
      r_b_sel    <= B_SEL_RS2;
      r_imm      <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
      r_rd_wen   <= 1'b0;
    end else if (w_capture) begin
      r_pc       <= i_id_pc;
      r_alu_opt  <= i_id_alu_opt;
      r_a_sel    <= i_id_a_sel;
      r_b_sel    <= i_id_b_sel;
      r_imm      <= i_id_imm;
      r_rs1_addr <= i_id_rs1_addr;
      r_rs2_addr <= i_id_rs2_addr;
      r_rd_addr  <= i_id_rd_addr;
      r_rd_wen   <= i_id_rd_wen;
    end
  end

  // While held, keep the source values current with anything retiring through WB.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rs1_data <= '0;
      r_rs2_data <= '0;
    end else if (w_capture) begin
      r_rs1_data <= w_rs1_cap;
      r_rs2_data <= w_rs2_cap;
    end else if (r_valid) begin
      if (w_rs1_snoop) begin
        r_rs1_data <= i_wb_data;
      end
      if (w_rs2_snoop) begin
        r_rs2_data <= i_wb_data;
      end
    end
  end

  ysyx_23060077_riscv_ex_fwd #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_rs1 (
    .i_addr     (r_rs1_addr),
    .i_data     (r_rs1_data),
    .i_mem_wen  (i_mem_fwd_wen),
    .i_mem_addr (i_mem_fwd_addr),
    .i_mem_data (i_mem_fwd_data),
    .i_wb_wen   (i_wb_wen),
    .i_wb_addr  (i_wb_addr),
    .i_wb_data  (i_wb_data),
    .o_data     (w_rs1_fwd)
  );

  ysyx_23060077_riscv_ex_fwd #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_rs2 (
    .i_addr     (r_rs2_addr),
    .i_data     (r_rs2_data),
    .i_mem_wen  (i_mem_fwd_wen),
    .i_mem_addr (i_mem_fwd_addr),
    .i_mem_data (i_mem_fwd_data),
    .i_wb_wen   (i_wb_wen),
    .i_wb_addr  (i_wb_addr),
    .i_wb_data  (i_wb_data),
    .o_data     (w_rs2_fwd)
  );

  assign o_id_ready      = w_id_ready;
  assign o_ex_valid      = r_valid;
  assign o_ex_pc         = r_pc;
  assign o_ex_alu_opt    = r_alu_opt;
  assign o_ex_alu_a_data = (r_a_sel == A_SEL_PC) ? r_pc : w_rs1_fwd;
  assign o_ex_alu_b_data = (r_b_sel == B_SEL_IMM) ? r_imm : w_rs2_fwd;
  assign o_ex_store_data = w_rs2_fwd;
  assign o_ex_rd_addr    = r_rd_addr;
  assign o_ex_rd_wen     = r_rd_wen && r_valid;

endmodule

// File: tb/tb_ysyx_23060077_riscv_id_ex_stage.sv
// Self-checking bench for the ID/EX stage: directed vector table, hand-written
// stall/reset/flush sequences and a randomized run against a behavioural model.
module tb_ysyx_23060077_riscv_id_ex_stage;
  import ysyx_23060077_riscv_id_ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rstN;
  logic        flush;
  logic        idValid;
  logic        idReady;
  logic [31:0] idPc;
  logic [3:0]  idAluOpt;
  logic        idASel;
  logic        idBSel;
  logic [31:0] idImm;
  logic [4:0]  idRs1Addr;
  logic [4:0]  idRs2Addr;
  logic [31:0] idRs1Data;
  logic [31:0] idRs2Data;
  logic [4:0]  idRdAddr;
  logic        idRdWen;
  logic        memWen;
  logic [4:0]  memAddr;
  logic [31:0] memData;
  logic        wbWen;
  logic [4:0]  wbAddr;
  logic [31:0] wbData;
  logic        exValid;
  logic        exReady;
  logic [31:0] exPc;
  logic [3:0]  exAluOpt;
  logic [31:0] exAData;
  logic [31:0] exBData;
  logic [31:0] exStoreData;
  logic [4:0]  exRdAddr;
  logic        exRdWen;

  int total = 0;
  int bad   = 0;

  // Abstract view of the single held instruction.
  logic        mValid;
  logic [31:0] mPc;
  logic [3:0]  mOpt;
  logic        mASel;
  logic        mBSel;
  logic [31:0] mImm;
  logic [4:0]  mRs1;
  logic [4:0]  mRs2;
  logic [31:0] mD1;
  logic [31:0] mD2;
  logic [4:0]  mRd;
  logic        mRdWen;

  typedef struct {
    logic [3:0]  opt;
    logic        aSel;
    logic        bSel;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        capWbWen;
    logic [4:0]  capWbAddr;
    logic [31:0] capWbData;
    logic        holdMemWen;
    logic [4:0]  holdMemAddr;
    logic [31:0] holdMemData;
    logic        holdWbWen;
    logic [4:0]  holdWbAddr;
    logic [31:0] holdWbData;
    logic [31:0] expA;
    logic [31:0] expB;
    logic [31:0] expStore;
  } vec_t;

  vec_t vecs[7];

  ysyx_23060077_riscv_id_ex_stage dut (
    .i_clk           (clk),
    .i_rst_n         (rstN),
    .i_flush         (flush),
    .i_id_valid      (idValid),
    .o_id_ready      (idReady),
    .i_id_pc         (idPc),
    .i_id_alu_opt    (idAluOpt),
    .i_id_a_sel      (idASel),
    .i_id_b_sel      (idBSel),
    .i_id_imm        (idImm),
    .i_id_rs1_addr   (idRs1Addr),
    .i_id_rs2_addr   (idRs2Addr),
    .i_id_rs1_data   (idRs1Data),
    .i_id_rs2_data   (idRs2Data),
    .i_id_rd_addr    (idRdAddr),
    .i_id_rd_wen     (idRdWen),
    .i_mem_fwd_wen   (memWen),
    .i_mem_fwd_addr  (memAddr),
    .i_mem_fwd_data  (memData),
    .i_wb_wen        (wbWen),
    .i_wb_addr       (wbAddr),
    .i_wb_data       (wbData),
    .o_ex_valid      (exValid),
    .i_ex_ready      (exReady),
    .o_ex_pc         (exPc),
    .o_ex_alu_opt    (exAluOpt),
    .o_ex_alu_a_data (exAData),
    .o_ex_alu_b_data (exBData),
    .o_ex_store_data (exStoreData),
    .o_ex_rd_addr    (exRdAddr),
    .o_ex_rd_wen     (exRdWen)
  );

  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Value a source register reads as, given the current bypass ports.
  function automatic logic [31:0] regValue(input logic [4:0] addr, input logic [31:0] held);
    if (addr == 5'd0) return 32'h0;
    if (memWen && memAddr == addr) return memData;
    if (wbWen && wbAddr == addr) return wbData;
    return held;
  endfunction

  task automatic modelReset();
    mValid = 1'b0; mPc = '0; mOpt = '0; mASel = 1'b0; mBSel = 1'b0; mImm = '0;
    mRs1 = '0; mRs2 = '0; mD1 = '0; mD2 = '0; mRd = '0; mRdWen = 1'b0;
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic modelUpdate();
    logic canTake;
    canTake = !mValid || exReady;
    if (flush) begin
      mValid = 1'b0;
    end else if (canTake && idValid) begin
      mValid = 1'b1; mPc = idPc; mOpt = idAluOpt; mASel = idASel; mBSel = idBSel;
      mImm = idImm; mRs1 = idRs1Addr; mRs2 = idRs2Addr; mRd = idRdAddr; mRdWen = idRdWen;
      mD1 = (wbWen && wbAddr == idRs1Addr && idRs1Addr != 0) ? wbData : idRs1Data;
      mD2 = (wbWen && wbAddr == idRs2Addr && idRs2Addr != 0) ? wbData : idRs2Data;
    end else if (canTake) begin
      mValid = 1'b0;
    end else begin
      if (wbWen && wbAddr == mRs1 && mRs1 != 0) mD1 = wbData;
      if (wbWen && wbAddr == mRs2 && mRs2 != 0) mD2 = wbData;
    end
  endtask

  task automatic clockEdge();
    modelUpdate();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    flush = 0; idValid = 0; idPc = '0; idAluOpt = '0; idASel = 0; idBSel = 0; idImm = '0;
    idRs1Addr = '0; idRs2Addr = '0; idRs1Data = '0; idRs2Data = '0; idRdAddr = '0; idRdWen = 0;
    memWen = 0; memAddr = '0; memData = '0; wbWen = 0; wbAddr = '0; wbData = '0; exReady = 1;
  endtask

  task automatic applyStimulus(input logic [3:0] opt, input logic aSel, input logic bSel,
                               input logic [31:0] pc, input logic [31:0] imm,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] d1, input logic [31:0] d2,
                               input logic [4:0] rd, input logic rdWen);
    idValid = 1; idAluOpt = opt; idASel = aSel; idBSel = bSel; idPc = pc; idImm = imm;
    idRs1Addr = rs1; idRs2Addr = rs2; idRs1Data = d1; idRs2Data = d2;
    idRdAddr = rd; idRdWen = rdWen;
  endtask

  task automatic checkOutput(input string tag);
    #3;
    compare({tag, ".valid"}, {31'b0, exValid}, {31'b0, mValid});
    compare({tag, ".ready"}, {31'b0, idReady}, {31'b0, (!mValid || exReady)});
    compare({tag, ".rdwen"}, {31'b0, exRdWen}, {31'b0, (mValid && mRdWen)});
    if (mValid) begin
      compare({tag, ".pc"}, exPc, mPc);
      compare({tag, ".opt"}, {28'b0, exAluOpt}, {28'b0, mOpt});
      compare({tag, ".a"}, exAData, mASel ? mPc : regValue(mRs1, mD1));
      compare({tag, ".b"}, exBData, mBSel ? mImm : regValue(mRs2, mD2));
      compare({tag, ".store"}, exStoreData, regValue(mRs2, mD2));
      compare({tag, ".rd"}, {27'b0, exRdAddr}, {27'b0, mRd});
    end
  endtask

  initial begin
    int validCycles;

    vecs[0] = '{ALU_ADD, 1'b0, 1'b1, 32'h100, 32'hFFFF_FFFC, 5'd5, 5'd0, 32'h10, 32'h0,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                32'h10, 32'hFFFF_FFFC, 32'h0};
    vecs[1] = '{ALU_SUB, 1'b0, 1'b0, 32'h104, 32'h0, 5'd7, 5'd8, 32'h1, 32'h22,
                1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hAA, 1'b1, 5'd7, 32'hBB,
                32'hAA, 32'h22, 32'h22};
    vecs[2] = '{ALU_SUB, 1'b0, 1'b0, 32'h108, 32'h0, 5'd7, 5'd8, 32'h1, 32'h22,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hBB,
                32'hBB, 32'h22, 32'h22};
    vecs[3] = '{ALU_OR, 1'b0, 1'b0, 32'h10C, 32'h0, 5'd0, 5'd0, 32'h55, 32'h66,
                1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB,
                32'h0, 32'h0, 32'h0};
    vecs[4] = '{ALU_XOR, 1'b0, 1'b0, 32'h110, 32'h0, 5'd9, 5'd9, 32'h0, 32'h0,
                1'b1, 5'd9, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                32'h1234, 32'h1234, 32'h1234};
    vecs[5] = '{ALU_ADD, 1'b1, 1'b1, 32'h8000_0040, 32'h7FF, 5'd1, 5'd4, 32'h11, 32'h99,
                1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'hCAFE, 1'b0, 5'd0, 32'h0,
                32'h8000_0040, 32'h7FF, 32'hCAFE};
    vecs[6] = '{ALU_AND, 1'b0, 1'b0, 32'h114, 32'h0, 5'd3, 5'd6, 32'h3, 32'h6,
                1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd3, 32'h33,
                32'h33, 32'h66, 32'h66};

    // Reset state
    clearInputs();
    rstN = 0;
    modelReset();
    #3;
    compare("rst.valid", {31'b0, exValid}, 32'h0);
    compare("rst.rdwen", {31'b0, exRdWen}, 32'h0);
    compare("rst.a", exAData, 32'h0);
    compare("rst.b", exBData, 32'h0);
    compare("rst.store", exStoreData, 32'h0);
    compare("rst.pc", exPc, 32'h0);
    repeat (2) @(posedge clk);
    #1 rstN = 1;
    checkOutput("rel");

    // Directed vectors: capture, then hold one stalled cycle with the given bypass traffic
    for (int i = 0; i < 7; i++) begin
      clearInputs();
      applyStimulus(vecs[i].opt, vecs[i].aSel, vecs[i].bSel, vecs[i].pc, vecs[i].imm,
                    vecs[i].rs1, vecs[i].rs2, vecs[i].d1, vecs[i].d2, 5'(10 + i), 1'b1);
      wbWen = vecs[i].capWbWen; wbAddr = vecs[i].capWbAddr; wbData = vecs[i].capWbData;
      checkOutput($sformatf("vec%0d.cap", i));
      clockEdge();
      clearInputs();
      exReady = 0;
      memWen = vecs[i].holdMemWen; memAddr = vecs[i].holdMemAddr; memData = vecs[i].holdMemData;
      wbWen = vecs[i].holdWbWen; wbAddr = vecs[i].holdWbAddr; wbData = vecs[i].holdWbData;
      checkOutput($sformatf("vec%0d.hold", i));
      compare($sformatf("vec%0d.expA", i), exAData, vecs[i].expA);
      compare($sformatf("vec%0d.expB", i), exBData, vecs[i].expB);
      compare($sformatf("vec%0d.expStore", i), exStoreData, vecs[i].expStore);
      compare($sformatf("vec%0d.expOpt", i), {28'b0, exAluOpt}, {28'b0, vecs[i].opt});
      compare($sformatf("vec%0d.expValid", i), {31'b0, exValid}, 32'h1);
      clockEdge();
      clearInputs();
      checkOutput($sformatf("vec%0d.drain", i));
      clockEdge();
    end

    // Stall snoop: WB retires x3 past a stalled reader, then goes idle
    clearInputs();
    applyStimulus(ALU_ADD, 1'b0, 1'b0, 32'h200, 32'h0, 5'd2, 5'd3, 32'h2, 32'h5, 5'd4, 1'b1);
    checkOutput("snoop.cap");
    clockEdge();
    clearInputs();
    exReady = 0; wbWen = 1; wbAddr = 5'd3; wbData = 32'h77;
    checkOutput("snoop.wb");
    clockEdge();
    clearInputs();
    exReady = 0;
    for (int k = 0; k < 2; k++) begin
      checkOutput("snoop.idle");
      compare("snoop.b", exBData, 32'h77);
      compare("snoop.store", exStoreData, 32'h77);
      clockEdge();
    end

    // Async reset while stalled with a valid instruction
    compare("rststall.pre", {31'b0, exValid}, 32'h1);
    #1 rstN = 0;
    #1;
    compare("rststall.valid", {31'b0, exValid}, 32'h0);
    compare("rststall.rdwen", {31'b0, exRdWen}, 32'h0);
    modelReset();
    @(posedge clk);
    #1 rstN = 1;
    exReady = 0;
    checkOutput("rststall.rel");
    compare("rststall.ready", {31'b0, idReady}, 32'h1);
    clockEdge();

    // Flush during a firing handshake drops the instruction
    clearInputs();
    applyStimulus(ALU_ADD, 1'b0, 1'b1, 32'h300, 32'h4, 5'd1, 5'd2, 32'h1, 32'h2, 5'd5, 1'b1);
    flush = 1;
    checkOutput("flush.fire");
    clockEdge();
    clearInputs();
    checkOutput("flush.after");
    compare("flush.valid", {31'b0, exValid}, 32'h0);
    compare("flush.rdwen", {31'b0, exRdWen}, 32'h0);

    // Back-to-back stream of four with EX always ready
    validCycles = 0;
    for (int k = 0; k < 5; k++) begin
      clearInputs();
      if (k < 4)
        applyStimulus(ALU_ADD, 1'b1, 1'b1, 32'h400 + 32'(4 * k), 32'(k), 5'd0, 5'd0,
                      32'h0, 32'h0, 5'(k + 1), 1'b1);
      checkOutput($sformatf("stream%0d", k));
      if (k > 0 && exValid === 1'b1) validCycles++;
      clockEdge();
    end
    compare("stream.count", 32'(validCycles), 32'd4);
    clearInputs();
    checkOutput("stream.end");
    compare("stream.endvalid", {31'b0, exValid}, 32'h0);
    clockEdge();

    // Randomized traffic with a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      clearInputs();
      flush     = ($urandom_range(0, 15) == 0);
      idValid   = $urandom_range(0, 1);
      exReady   = ($urandom_range(0, 3) != 0);
      idPc      = $urandom;
      idAluOpt  = 4'($urandom_range(0, 10));
      idASel    = $urandom_range(0, 1);
      idBSel    = $urandom_range(0, 1);
      idImm     = $urandom;
      idRs1Addr = 5'($urandom_range(0, 3));
      idRs2Addr = 5'($urandom_range(0, 3));
      idRs1Data = $urandom;
      idRs2Data = $urandom;
      idRdAddr  = 5'($urandom_range(0, 31));
      idRdWen   = $urandom_range(0, 1);
      memWen    = $urandom_range(0, 1);
      memAddr   = 5'($urandom_range(0, 3));
      memData   = $urandom;
      wbWen     = $urandom_range(0, 1);
      wbAddr    = 5'($urandom_range(0, 3));
      wbData    = $urandom;
      checkOutput("rand");
      clockEdge();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
